sgd_update_engine: RTL and testbench

Parametrised successor to the single-mode RBM weight updater. Streams over an I_TILE×H_TILE accumulator tile and applies lr·(pos−neg) − wd·w to Q1.15 weights, with an optional momentum (velocity) buffer.
Supports configurable BRAM read latency at full one-element-per-cycle throughput, plus abort and a saturation counter. Sits between the CD-k accumulator banks and the weight/velocity BRAMs; the host controller drives start.

---
 rtl/sgd_update_engine.sv | 190 +++++++++++++++++++
 tb/tb_sgd_update_engine.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/sgd_update_engine.sv
// SGD weight updater: streams an I_TILE x H_TILE tile, w += lr*(pos-neg) - wd*w, optional momentum.
// Latency: address k issued at cycle 1+k, write of k at cycle 2+k+RD_LAT, done at N+2+RD_LAT.
// No backpressure: one element per cycle; abort cancels the run and drops in-flight writes.
module sgd_update_engine #(
    parameter int I_TILE = 16,
    parameter int H_TILE = 16,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [15:0]       lr,
    input  logic [15:0]       wd,
    input  logic [15:0]       mom,
    input  logic              mom_en,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [ACC_W-1:0]  acc_pos_d,
    input  logic [ACC_W-1:0]  acc_neg_d,
    input  logic [15:0]       w_d,
    input  logic [15:0]       v_d,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       w_q,
    output logic              w_we,
    output logic [15:0]       v_q,
    output logic              v_we,
    output logic [ADDR_W-1:0] sat_cnt
);
    // Full-width intermediate: (ACC_W+1)-bit difference times 17-bit unsigned rate.
    localparam int PW = ACC_W + 18;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(I_TILE * H_TILE - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en, r_busy, r_done, r_aborted;
    logic [15:0]         r_lr, r_wd, r_mom;
    logic                r_mom_en;
    logic [RD_LAT-1:0]   r_dv;
    logic [RD_LAT-1:0][ADDR_W-1:0] r_di;
    logic [ADDR_W-1:0]   r_wr_addr, r_sat_cnt;
    logic [15:0]         r_w_q, r_v_q;
    logic                r_w_we, r_v_we;

    logic                w_start, w_kill, w_last_vld;
    logic signed [ACC_W:0]  w_diff;
    logic signed [PW-1:0]   w_g_prod, w_g, w_wx, w_vx, w_t_prod, w_t, w_m_prod, w_m;
    logic signed [PW-1:0]   w_v_sum, w_v_newx, w_w_sum;
    logic [15:0]            w_v_new, w_w_new;
    logic                   w_w_clamp;

    // Clamp a wide signed value into Q1.15.
    function automatic logic [15:0] sat16(input logic signed [PW-1:0] x);
        if ((&x[PW-1:15]) || !(|x[PW-1:15])) return x[15:0];
        else if (x[PW-1])                    return 16'h8000;
        else                                 return 16'h7FFF;
    endfunction

    function automatic logic ovf16(input logic signed [PW-1:0] x);
        return !((&x[PW-1:15]) || !(|x[PW-1:15]));
    endfunction

    assign w_start    = (r_state == S_IDLE) && start;
    assign w_kill     = (r_state != S_IDLE) && abort;
    assign w_last_vld = r_dv[RD_LAT-1] && !w_kill;

    // Update arithmetic; all shifts are arithmetic so results floor toward -inf.
    assign w_diff   = $signed({acc_pos_d[ACC_W-1], acc_pos_d}) - $signed({acc_neg_d[ACC_W-1], acc_neg_d});
    assign w_g_prod = $signed({{17{w_diff[ACC_W]}}, w_diff}) * $signed({{(PW-16){1'b0}}, r_lr});
    assign w_g      = w_g_prod >>> 24;
    assign w_wx     = $signed({{(PW-16){w_d[15]}}, w_d});
    assign w_vx     = $signed({{(PW-16){v_d[15]}}, v_d});
    assign w_t_prod = w_wx * $signed({{(PW-16){1'b0}}, r_wd});
    assign w_t      = w_t_prod >>> 16;
    assign w_m_prod = w_vx * $signed({{(PW-16){1'b0}}, r_mom});
    assign w_m      = w_m_prod >>> 16;
    assign w_v_sum  = w_m + w_g - w_t;
    assign w_v_new  = sat16(w_v_sum);
    assign w_v_newx = $signed({{(PW-16){w_v_new[15]}}, w_v_new});
    assign w_w_sum  = r_mom_en ? (w_wx + w_v_newx) : (w_wx + w_g - w_t);
    assign w_w_new  = sat16(w_w_sum);
    assign w_w_clamp = ovf16(w_w_sum);

    // Control FSM: address issue, drain wait, done/aborted pulses, config latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_lr      <= '0;
            r_wd      <= '0;
            r_mom     <= '0;
            r_mom_en  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    r_lr      <= lr;
                    r_wd      <= wd;
                    r_mom     <= mom;
                    r_mom_en  <= mom_en;
                    r_rd_addr <= '0;
                    r_rd_en   <= 1'b1;
                    r_busy    <= 1'b1;
                    r_state   <= S_ISSUE;
                end
            end else if (abort) begin
                r_rd_en   <= 1'b0;
                r_busy    <= 1'b0;
                r_aborted <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_ISSUE: begin
                        if (r_rd_addr == LAST) begin
                            r_rd_en <= 1'b0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_rd_addr <= r_rd_addr + 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        // Delay line empty means the final write is on the outputs this cycle.
                        if (r_dv == '0) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FIN;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Valid/index delay line matching BRAM latency, then the registered write stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dv      <= '0;
            r_di      <= '0;
            r_wr_addr <= '0;
            r_w_q     <= '0;
            r_v_q     <= '0;
            r_w_we    <= 1'b0;
            r_v_we    <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            r_dv[0] <= r_rd_en && !w_kill;
            r_di[0] <= r_rd_addr;
            for (int j = 1; j < RD_LAT; j++) begin
                r_dv[j] <= r_dv[j-1] && !w_kill;
                r_di[j] <= r_di[j-1];
            end
            r_w_we <= w_last_vld;
            r_v_we <= w_last_vld && r_mom_en;
            if (w_last_vld) begin
                r_wr_addr <= r_di[RD_LAT-1];
                r_w_q     <= w_w_new;
                r_v_q     <= w_v_new;
                if (w_w_clamp && (r_sat_cnt != '1))
                    r_sat_cnt <= r_sat_cnt + 1'b1;
            end
            if (w_start)
                r_sat_cnt <= '0;
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign rd_addr = r_rd_addr;
    assign rd_en   = r_rd_en;
    assign wr_addr = r_wr_addr;
    assign w_q     = r_w_q;
    assign w_we    = r_w_we;
    assign v_q     = r_v_q;
    assign v_we    = r_v_we;
    assign sat_cnt = r_sat_cnt;
endmodule

// File: tb/tb_sgd_update_engine.sv
// Bench for sgd_update_engine: 2x2 tile, one instance at RD_LAT=1 and one at RD_LAT=3.
// Constant BRAM data per vector; outputs sampled on the falling edge.
// Cycle 0 is the rising edge that samples start.
module tb_sgd_update_engine;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, mom_en, sel;
    logic [15:0] lr, wd, mom, w_d, v_d;
    logic [31:0] acc_pos_d, acc_neg_d;
    logic        start1, start3;

    logic          busy1, done1, aborted1, rd_en1, w_we1, v_we1;
    logic [AW-1:0] rd_addr1, wr_addr1, sat_cnt1;
    logic [15:0]   w_q1, v_q1;
    logic          busy3, done3, aborted3, rd_en3, w_we3, v_we3;
    logic [AW-1:0] rd_addr3, wr_addr3, sat_cnt3;
    logic [15:0]   w_q3, v_q3;

    assign start1 = start & ~sel;
    assign start3 = start & sel;

    sgd_update_engine #(.I_TILE(2), .H_TILE(2), .ACC_W(32), .ADDR_W(AW), .RD_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort & ~sel),
        .lr(lr), .wd(wd), .mom(mom), .mom_en(mom_en),
        .busy(busy1), .done(done1), .aborted(aborted1),
        .rd_addr(rd_addr1), .rd_en(rd_en1),
        .acc_pos_d(acc_pos_d), .acc_neg_d(acc_neg_d), .w_d(w_d), .v_d(v_d),
        .wr_addr(wr_addr1), .w_q(w_q1), .w_we(w_we1), .v_q(v_q1), .v_we(v_we1),
        .sat_cnt(sat_cnt1));

    sgd_update_engine #(.I_TILE(2), .H_TILE(2), .ACC_W(32), .ADDR_W(AW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort & sel),
        .lr(lr), .wd(wd), .mom(mom), .mom_en(mom_en),
        .busy(busy3), .done(done3), .aborted(aborted3),
        .rd_addr(rd_addr3), .rd_en(rd_en3),
        .acc_pos_d(acc_pos_d), .acc_neg_d(acc_neg_d), .w_d(w_d), .v_d(v_d),
        .wr_addr(wr_addr3), .w_q(w_q3), .w_we(w_we3), .v_q(v_q3), .v_we(v_we3),
        .sat_cnt(sat_cnt3));

    // Selected instance's outputs
    logic          m_busy, m_done, m_aborted, m_rd_en, m_w_we, m_v_we;
    logic [AW-1:0] m_rd_addr, m_wr_addr, m_sat_cnt;
    logic [15:0]   m_w_q, m_v_q;
    assign m_busy    = sel ? busy3    : busy1;
    assign m_done    = sel ? done3    : done1;
    assign m_aborted = sel ? aborted3 : aborted1;
    assign m_rd_en   = sel ? rd_en3   : rd_en1;
    assign m_w_we    = sel ? w_we3    : w_we1;
    assign m_v_we    = sel ? v_we3    : v_we1;
    assign m_rd_addr = sel ? rd_addr3 : rd_addr1;
    assign m_wr_addr = sel ? wr_addr3 : wr_addr1;
    assign m_sat_cnt = sel ? sat_cnt3 : sat_cnt1;
    assign m_w_q     = sel ? w_q3     : w_q1;
    assign m_v_q     = sel ? v_q3     : v_q1;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] pos, neg;
        logic [15:0] w, v, lr, wd, mom;
        logic        me;
        logic [15:0] ew, ev, esat;
    } vec_t;

    vec_t tv[9];

    task automatic apply(input vec_t t);
        acc_pos_d = t.pos; acc_neg_d = t.neg; w_d = t.w; v_d = t.v;
        lr = t.lr; wd = t.wd; mom = t.mom; mom_en = t.me;
    endtask

    // Full run on the selected instance, checking every cycle against the nominal timeline.
    task automatic run(input vec_t t, input int lat, input string tag);
        logic is_rd, is_wr;
        @(negedge clk);
        apply(t);
        start = 1'b1;
        for (int c = 1; c <= lat + 8; c++) begin
            @(negedge clk);
            start = 1'b0;
            is_rd = (c >= 1) && (c <= 4);
            is_wr = (c >= 2 + lat) && (c <= 5 + lat);
            chk({tag, " rd_en"}, 64'(m_rd_en), 64'(is_rd));
            if (is_rd) chk({tag, " rd_addr"}, 64'(m_rd_addr), 64'(c - 1));
            chk({tag, " w_we"}, 64'(m_w_we), 64'(is_wr));
            chk({tag, " v_we"}, 64'(m_v_we), 64'(is_wr && t.me));
            if (is_wr) begin
                chk({tag, " wr_addr"}, 64'(m_wr_addr), 64'(c - 2 - lat));
                chk({tag, " w_q"}, 64'(m_w_q), 64'(t.ew));
                if (t.me) chk({tag, " v_q"}, 64'(m_v_q), 64'(t.ev));
            end
            chk({tag, " done"}, 64'(m_done), 64'(c == 6 + lat));
            chk({tag, " busy"}, 64'(m_busy), 64'((c >= 1) && (c <= 5 + lat)));
        end
        chk({tag, " sat_cnt"}, 64'(m_sat_cnt), 64'(t.esat));
    endtask

    initial begin
        //         pos            neg            w        v        lr       wd       mom      me    ew       ev       esat
        tv[0] = '{32'h0080_0000, 32'h0,        16'h0000, 16'h0,   16'h8000, 16'h0,   16'h0,   1'b0, 16'h4000, 16'h0,   16'd0};
        tv[1] = '{32'h0,        32'h0,        16'h4000, 16'h0,   16'h0,   16'h8000, 16'h0,   1'b0, 16'h2000, 16'h0,   16'd0};
        tv[2] = '{32'h0,        32'h0,        16'hC000, 16'h0,   16'h0,   16'h8000, 16'h0,   1'b0, 16'hE000, 16'h0,   16'd0};
        tv[3] = '{32'h0080_0000, 32'h0,        16'h7000, 16'h0,   16'h8000, 16'h0,   16'h0,   1'b0, 16'h7FFF, 16'h0,   16'd4};
        tv[4] = '{32'h0,        32'h0080_0000, 16'h9000, 16'h0,   16'h8000, 16'h0,   16'h0,   1'b0, 16'h8000, 16'h0,   16'd4};
        tv[5] = '{32'h0080_0000, 32'h0,        16'h1000, 16'h2000, 16'h8000, 16'h0,   16'h8000, 1'b1, 16'h6000, 16'h5000, 16'd0};
        tv[6] = '{32'h0,        32'h1,        16'h0000, 16'h0,   16'h0001, 16'h0,   16'h0,   1'b0, 16'hFFFF, 16'h0,   16'd0};
        tv[7] = '{32'h0080_0000, 32'h0,        16'h1000, 16'h7000, 16'h8000, 16'h0,   16'hFFFF, 1'b1, 16'h7FFF, 16'h7FFF, 16'd4};
        tv[8] = '{32'h0,        32'h0,        16'hFFFF, 16'h0,   16'h0,   16'h0001, 16'h0,   1'b0, 16'h0000, 16'h0,   16'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0; sel = 1'b0;
        apply(tv[0]);
        repeat (3) @(negedge clk);
        chk("reset ctl1", 64'({busy1, done1, aborted1, rd_en1, w_we1, v_we1}), 64'(0));
        chk("reset dat1", {rd_addr1, wr_addr1, w_q1, v_q1}, 64'(0));
        chk("reset sat1", 64'(sat_cnt1), 64'(0));
        chk("reset ctl3", 64'({busy3, done3, aborted3, rd_en3, w_we3, v_we3}), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 9; i++) run(tv[i], 1, $sformatf("vec%0d", i));

        // Abort at rd_addr=2, with a stray start while busy.
        @(negedge clk);
        apply(tv[0]);
        start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            start = (c == 2);
            abort = 1'b0;
            if (c == 3) begin
                chk("abort rd_addr", 64'(rd_addr1), 64'(2));
                chk("abort w_we pre", 64'(w_we1), 64'(1));
                abort = 1'b1;
            end
            if (c == 4) begin
                chk("abort pulse", 64'(aborted1), 64'(1));
                chk("abort busy", 64'(busy1), 64'(0));
                chk("abort rd_en", 64'(rd_en1), 64'(0));
            end
            if (c >= 4) begin
                chk("abort w_we", 64'(w_we1), 64'(0));
                chk("abort done", 64'(done1), 64'(0));
            end
            if (c >= 5) chk("abort pulse len", 64'(aborted1), 64'(0));
        end
        run(tv[0], 1, "post_abort");

        sel = 1'b1;
        run(tv[0], 3, "lat3");
        run(tv[7], 3, "lat3_sat");

        // Reset mid-run on the RD_LAT=3 instance.
        @(negedge clk);
        apply(tv[5]);
        start = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 6) begin
                chk("rst mid w_we", 64'(w_we3), 64'(1));
                rst = 1'b1;
            end
            if (c == 7) begin
                chk("rst mid ctl", 64'({busy3, done3, aborted3, rd_en3, w_we3, v_we3}), 64'(0));
                chk("rst mid dat", {rd_addr3, wr_addr3, w_q3, v_q3}, 64'(0));
                chk("rst mid sat", 64'(sat_cnt3), 64'(0));
                rst = 1'b0;
            end
            if (c >= 7) begin
                chk("rst mid no write", 64'({w_we3, v_we3}), 64'(0));
                chk("rst mid no done", 64'({done3, aborted3}), 64'(0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
